// File: rtl/online_pkg.sv
// rtl/online_pkg.sv - shared digit types, FSM states and digit helpers for the on-line SD adder
//
// Purpose: common definitions for online_sd_adder_mc and online_sd_add_lane.
//   sd_digit_t  : borrow-save signed digit {plus, minus}; (1,0)=+1, (0,1)=-1, else 0
//   state_t     : frame FSM states (ACCEPT, FLUSH1, FLUSH2)
//   tw_t        : transfer/residual pair produced by the digit selection rule
//   sd_to_int   : borrow-save digit to -1/0/+1
//   int_to_sd   : -1/0/+1 to canonical borrow-save digit (never (1,1))
//   select_tw   : (t,w) selection from s_j and the look-ahead s_{j+1}
package online_pkg;

  typedef struct packed {
    logic plus;
    logic minus;
  } sd_digit_t;

  // Two look-ahead/flush steps between the last input digit and the last output digit.
  localparam int ONLINE_DELAY = 2;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_FLUSH1 = 2'd1,
    ST_FLUSH2 = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [1:0] t;
    logic signed [1:0] w;
  } tw_t;

  function automatic logic signed [1:0] sd_to_int(input sd_digit_t d);
    logic signed [1:0] v;
    v = 2'sd0;
    if (d.plus && !d.minus) begin
      v = 2'sd1;
    end else if (!d.plus && d.minus) begin
      v = -2'sd1;
    end
    return v;
  endfunction

  function automatic sd_digit_t int_to_sd(input logic signed [1:0] v);
    sd_digit_t d;
    d.plus  = (v == 2'sd1);
    d.minus = (v == -2'sd1);
    return d;
  endfunction

  // s in {-2..2}; s_next decides whether a +-1 is pushed up as a transfer
  // or kept as a residual, so that w + t of the next position stays in {-1,0,1}.
  function automatic tw_t select_tw(input logic signed [2:0] s,
                                    input logic signed [2:0] s_next);
    tw_t r;
    r.t = 2'sd0;
    r.w = 2'sd0;
    if (s == 3'sd2) begin
      r.t = 2'sd1;
    end else if (s == -3'sd2) begin
      r.t = -2'sd1;
    end else if (s == 3'sd1) begin
      if (s_next >= 3'sd0) begin
        r.t = 2'sd1;
        r.w = -2'sd1;
      end else begin
        r.w = 2'sd1;
      end
    end else if (s == -3'sd1) begin
      if (s_next >= 3'sd0) begin
        r.w = -2'sd1;
      end else begin
        r.t = -2'sd1;
        r.w = 2'sd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/online_sd_add_lane.sv
// rtl/online_sd_add_lane.sv - one lane of the on-line SD adder: s/t/w history and z generation
//
// Purpose: forms s_j = x_j +- y_j for the digit presented in the current step,
//   resolves (t,w) of the previous digit using s_j as look-ahead and offers
//   z = w_pending + t combinationally; history advances on i_step.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   i_step     : shared step strobe (history advances)
//   i_first    : step carries digit 0 (sub is captured)
//   i_zero     : inject a zero digit (flush steps)
//   i_clr      : last step of the frame; history cleared instead of updated
//   i_sub      : subtract request, only meaningful with digit 0
//   i_x, i_y   : operand digits (borrow-save)
//   o_z        : result digit for this step (canonical)
module online_sd_add_lane
  import online_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_step,
  input  logic      i_first,
  input  logic      i_zero,
  input  logic      i_clr,
  input  logic      i_sub,
  input  sd_digit_t i_x,
  input  sd_digit_t i_y,
  output sd_digit_t o_z
);

  logic signed [2:0] r_s_prev;
  logic signed [1:0] r_w_prev;
  logic              r_sub;

  logic              w_sub;
  logic signed [1:0] w_xv;
  logic signed [1:0] w_yv;
  logic signed [2:0] w_x3;
  logic signed [2:0] w_y3;
  logic signed [2:0] w_s;
  logic signed [2:0] w_zsum;
  tw_t               w_tw;

  always_comb begin
    w_sub = i_first ? i_sub : r_sub;
    w_xv  = sd_to_int(i_x);
    w_yv  = sd_to_int(i_y);
    w_x3  = {w_xv[1], w_xv};
    w_y3  = {w_yv[1], w_yv};
    w_s   = 3'sd0;
    if (!i_zero) begin
      w_s = w_sub ? (w_x3 - w_y3) : (w_x3 + w_y3);
    end
    // (t,w) of the previous digit; its look-ahead is the digit arriving now.
    // After a clear r_s_prev=0, so digit 0's step yields t=w=0 and no stale residual.
    w_tw   = select_tw(r_s_prev, w_s);
    w_zsum = {r_w_prev[1], r_w_prev} + {w_tw.t[1], w_tw.t};
    o_z    = int_to_sd(w_zsum[1:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s_prev <= '0;
      r_w_prev <= '0;
      r_sub    <= 1'b0;
    end else if (i_step) begin
      if (i_clr) begin
        r_s_prev <= '0;
        r_w_prev <= '0;
        r_sub    <= 1'b0;
      end else begin
        r_s_prev <= w_s;
        r_w_prev <= w_tw.w;
        r_sub    <= w_sub;
      end
    end
  end

endmodule

// File: rtl/online_sd_adder_mc.sv
// rtl/online_sd_adder_mc.sv - multi-lane framed on-line SD adder/subtractor, on-line delay 2
//
// Purpose: LANES independent MSD-first signed-digit adders sharing one valid/ready
//   handshake; each DIGITS-digit frame yields DIGITS+1 result digits.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid, in_ready  : input digit handshake (digit j of every lane)
//   sub                 : per-lane subtract, captured with digit 0
//   x_plus/x_minus      : per-lane x digit (borrow-save)
//   y_plus/y_minus      : per-lane y digit (borrow-save)
//   out_valid, out_ready: output digit handshake
//   z_plus/z_minus      : per-lane canonical result digit
//   out_first, out_last : mark z_0 and z_DIGITS
//   busy                : frame in progress or output pending
module online_sd_adder_mc
  import online_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int DIGITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] sub,
  input  logic [LANES-1:0] x_plus,
  input  logic [LANES-1:0] x_minus,
  input  logic [LANES-1:0] y_plus,
  input  logic [LANES-1:0] y_minus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] z_plus,
  output logic [LANES-1:0] z_minus,
  output logic             out_first,
  output logic             out_last,
  output logic             busy
);

  localparam int            CW     = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] LAST_C = CW'(DIGITS - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;
  logic [LANES-1:0] r_z_plus;
  logic [LANES-1:0] r_z_minus;
  logic             r_out_first;
  logic             r_out_last;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_slot_free;
  logic             w_in_ready;
  logic             w_step;
  logic             w_load;
  logic             w_first;
  logic             w_last;
  logic             w_clr;
  logic             w_zero;
  logic             w_dig0;
  logic [LANES-1:0] w_z_plus;
  logic [LANES-1:0] w_z_minus;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_ACCEPT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_slot_free = !r_out_valid || out_ready;
    w_in_ready  = 1'b0;
    w_step      = 1'b0;
    w_load      = 1'b0;
    w_first     = 1'b0;
    w_last      = 1'b0;
    w_clr       = 1'b0;
    w_zero      = 1'b0;
    w_dig0      = 1'b0;
    case (r_state)
      ST_ACCEPT: begin
        w_in_ready = w_slot_free;
        w_step     = in_valid && w_slot_free;
        w_dig0     = (r_cnt == '0);
        // Digit 0 only primes the history; digit c produces z_{c-1}.
        w_load     = w_step && (r_cnt != '0);
        w_first    = (r_cnt == ONE_C);
        if (w_step) begin
          if (r_cnt == LAST_C) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_FLUSH1;
          end else begin
            w_cnt_nxt = r_cnt + ONE_C;
          end
        end
      end
      ST_FLUSH1: begin
        w_zero = 1'b1;
        w_step = w_slot_free;
        w_load = w_step;
        if (w_step) begin
          w_state_nxt = ST_FLUSH2;
        end
      end
      ST_FLUSH2: begin
        w_zero = 1'b1;
        w_step = w_slot_free;
        w_load = w_step;
        w_last = 1'b1;
        w_clr  = w_step;
        if (w_step) begin
          w_state_nxt = ST_ACCEPT;
        end
      end
      default: begin
        w_state_nxt = ST_ACCEPT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sd_digit_t w_zl;

    online_sd_add_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_step  (w_step),
      .i_first (w_dig0),
      .i_zero  (w_zero),
      .i_clr   (w_clr),
      .i_sub   (sub[l]),
      .i_x     (sd_digit_t'({x_plus[l], x_minus[l]})),
      .i_y     (sd_digit_t'({y_plus[l], y_minus[l]})),
      .o_z     (w_zl)
    );

    assign w_z_plus[l]  = w_zl.plus;
    assign w_z_minus[l] = w_zl.minus;
  end

  // A load in the same cycle as a consume replaces the digit and keeps valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_z_plus    <= '0;
      r_z_minus   <= '0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_z_plus    <= w_z_plus;
      r_z_minus   <= w_z_minus;
      r_out_first <= w_first;
      r_out_last  <= w_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign z_plus    = r_z_plus;
  assign z_minus   = r_z_minus;
  assign out_first = r_out_first;
  assign out_last  = r_out_last;
  assign busy      = (r_cnt != '0) || (r_state != ST_ACCEPT) || r_out_valid;

endmodule

// File: tb/tb_online_sd_adder_mc.sv
// tb/tb_online_sd_adder_mc.sv - self-checking bench for online_sd_adder_mc
module tb_online_sd_adder_mc;
  localparam int LANES  = 2;
  localparam int DIGITS = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] sub;
  logic [LANES-1:0] x_plus;
  logic [LANES-1:0] x_minus;
  logic [LANES-1:0] y_plus;
  logic [LANES-1:0] y_minus;
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] z_plus;
  logic [LANES-1:0] z_minus;
  logic             out_first;
  logic             out_last;
  logic             busy;

  online_sd_adder_mc #(.LANES(LANES), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .x_plus    (x_plus),
    .x_minus   (x_minus),
    .y_plus    (y_plus),
    .y_minus   (y_minus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z_plus    (z_plus),
    .z_minus   (z_minus),
    .out_first (out_first),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int e0;
    int e1;
    bit first;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   out_k = 0;
  int   cur_x[LANES][DIGITS];
  int   cur_y[LANES][DIGITS];
  bit   cur_sub[LANES];
  bit   cur_alt[LANES];
  int   acc_cyc[DIGITS];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int dec(input logic p, input logic m);
    return int'(p) - int'(m);
  endfunction

  function automatic logic [1:0] enc(input int d, input bit alt);
    if (d == 1) return 2'b10;
    if (d == -1) return 2'b01;
    return alt ? 2'b11 : 2'b00;
  endfunction

  // Whole-frame model: build the s sequence, pick every (t,w) by the selection rule, then form z.
  function automatic void model(input int x[DIGITS], input int y[DIGITS], input bit sb,
                                output int z[DIGITS+1]);
    int s[DIGITS+2];
    int t[DIGITS+1];
    int w[DIGITS+1];
    for (int j = 0; j < DIGITS + 2; j++) begin
      s[j] = 0;
      if (j < DIGITS) s[j] = sb ? (x[j] - y[j]) : (x[j] + y[j]);
    end
    for (int j = 0; j <= DIGITS; j++) begin
      t[j] = 0;
      w[j] = 0;
      case (s[j])
        2:  t[j] = 1;
        -2: t[j] = -1;
        1:  if (s[j+1] >= 0) begin t[j] = 1; w[j] = -1; end else w[j] = 1;
        -1: if (s[j+1] >= 0) w[j] = -1; else begin t[j] = -1; w[j] = 1; end
        default: ;
      endcase
    end
    z[0] = t[0];
    for (int k = 1; k <= DIGITS; k++) z[k] = w[k-1] + t[k];
  endfunction

  // Values in units of 2^-DIGITS.
  function automatic int val_z(input int z[DIGITS+1]);
    int v = 0;
    for (int k = 0; k <= DIGITS; k++) v += z[k] * (1 << (DIGITS - k));
    return v;
  endfunction

  function automatic int val_xy(input int x[DIGITS], input int y[DIGITS], input bit sb);
    int v = 0;
    for (int j = 0; j < DIGITS; j++) v += (sb ? (x[j] - y[j]) : (x[j] + y[j])) * (1 << (DIGITS - 1 - j));
    return v;
  endfunction

  task automatic set_lane(input int l, input int x0, input int x1, input int x2, input int x3,
                          input int y0, input int y1, input int y2, input int y3,
                          input bit sb, input bit alt);
    cur_x[l][0] = x0; cur_x[l][1] = x1; cur_x[l][2] = x2; cur_x[l][3] = x3;
    cur_y[l][0] = y0; cur_y[l][1] = y1; cur_y[l][2] = y2; cur_y[l][3] = y3;
    cur_sub[l] = sb;
    cur_alt[l] = alt;
  endtask

  task automatic run_frame(input int ndig, input bit push);
    int z0[DIGITS+1];
    int z1[DIGITS+1];
    bit got;
    if (push) begin
      model(cur_x[0], cur_y[0], cur_sub[0], z0);
      model(cur_x[1], cur_y[1], cur_sub[1], z1);
      check("model_value_lane0", val_z(z0), val_xy(cur_x[0], cur_y[0], cur_sub[0]));
      check("model_value_lane1", val_z(z1), val_xy(cur_x[1], cur_y[1], cur_sub[1]));
      for (int k = 0; k <= DIGITS; k++)
        exp_q.push_back('{e0: z0[k], e1: z1[k], first: (k == 0), last: (k == DIGITS)});
    end
    for (int j = 0; j < ndig; j++) begin
      got = 1'b0;
      for (int l = 0; l < LANES; l++) begin
        {x_plus[l], x_minus[l]} = enc(cur_x[l][j], cur_alt[l]);
        {y_plus[l], y_minus[l]} = enc(cur_y[l][j], cur_alt[l]);
        // sub is only meaningful with digit 0; drive the opposite afterwards.
        sub[l] = (j == 0) ? cur_sub[l] : ~cur_sub[l];
      end
      in_valid = 1'b1;
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk);
        if (in_ready) begin
          got = 1'b1;
          acc_cyc[j] = cyc;
        end
        @(posedge clk);
        #1;
      end
      if (!got) check("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic stall_z2();
    bit done = 1'b0;
    logic [LANES-1:0] hp;
    logic [LANES-1:0] hm;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk);
      #1;
      if (out_valid && out_k == 2) begin
        out_ready = 1'b0;
        hp = z_plus;
        hm = z_minus;
        repeat (3) begin
          @(negedge clk);
          check("stall_hold_z", int'({z_plus, z_minus}), int'({hp, hm}));
          check("stall_in_ready", int'(in_ready), 0);
          check("stall_out_valid", int'(out_valid), 1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
        done = 1'b1;
      end
    end
    if (!done) check("stall_timeout", 0, 1);
  endtask

  always @(negedge clk) begin : p_cmp
    exp_t e;
    if (rst_n && out_valid) begin
      check("canonical", int'((z_plus & z_minus) != '0), 0);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("z_lane0_k%0d", out_k), dec(z_plus[0], z_minus[0]), e.e0);
          check($sformatf("z_lane1_k%0d", out_k), dec(z_plus[1], z_minus[1]), e.e1);
          check($sformatf("out_first_k%0d", out_k), int'(out_first), int'(e.first));
          check($sformatf("out_last_k%0d", out_k), int'(out_last), int'(e.last));
        end
        out_k = (out_k == DIGITS) ? 0 : out_k + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1);
  end

  initial begin
    int px[DIGITS];
    int py[DIGITS];
    int pz[DIGITS+1];
    int pe[DIGITS+1];
    int t3;

    // Hand-computed vectors pin the model.
    px = '{1, 1, 0, -1};
    py = '{1, -1, -1, 0};
    model(px, py, 1'b0, pz);
    pe = '{1, 0, -1, 1, -1};
    for (int k = 0; k <= DIGITS; k++) check($sformatf("pin_add_k%0d", k), pz[k], pe[k]);
    model(px, py, 1'b1, pz);
    pe = '{0, 1, 0, 1, -1};
    for (int k = 0; k <= DIGITS; k++) check($sformatf("pin_sub_k%0d", k), pz[k], pe[k]);
    px = '{1, 1, 1, 1};
    model(px, px, 1'b0, pz);
    pe = '{1, 1, 1, 1, 0};
    for (int k = 0; k <= DIGITS; k++) check($sformatf("pin_ones_k%0d", k), pz[k], pe[k]);
    px = '{-1, -1, -1, -1};
    model(px, px, 1'b0, pz);
    pe = '{-1, -1, -1, -1, 0};
    for (int k = 0; k <= DIGITS; k++) check($sformatf("pin_negones_k%0d", k), pz[k], pe[k]);

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    sub = '0;
    x_plus = '0; x_minus = '0; y_plus = '0; y_minus = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_z", int'({z_plus, z_minus}), 0);
    check("rst_out_first", int'(out_first), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    set_lane(0, 1, 1, 0, -1, 1, -1, -1, 0, 1'b0, 1'b0);
    set_lane(1, 1, 1, 1, 1, 1, 1, 1, 1, 1'b0, 1'b0);
    run_frame(DIGITS, 1'b1);
    set_lane(0, 1, 1, 0, -1, 1, -1, -1, 0, 1'b1, 1'b0);
    set_lane(1, -1, -1, -1, -1, -1, -1, -1, -1, 1'b0, 1'b0);
    run_frame(DIGITS, 1'b1);
    drain();

    set_lane(0, 1, 1, 0, -1, 1, -1, -1, 0, 1'b0, 1'b0);
    set_lane(1, 1, 1, 0, -1, 1, -1, -1, 0, 1'b1, 1'b0);
    fork
      run_frame(DIGITS, 1'b1);
      stall_z2();
    join
    drain();

    out_ready = 1'b0;
    set_lane(1, 1, 1, 1, 1, 1, 1, 1, 1, 1'b0, 1'b0);
    run_frame(2, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_z", int'({z_plus, z_minus, out_first, out_last}), 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    set_lane(0, 1, 1, 0, -1, 1, -1, -1, 0, 1'b0, 1'b0);
    run_frame(DIGITS, 1'b1);
    drain();

    set_lane(0, 1, 1, 0, -1, 1, -1, -1, 0, 1'b0, 1'b0);
    set_lane(1, 1, 1, 0, -1, 1, -1, -1, 0, 1'b1, 1'b1);
    run_frame(DIGITS, 1'b1);
    t3 = acc_cyc[DIGITS-1];
    set_lane(0, 1, -1, 1, -1, -1, 1, -1, 1, 1'b1, 1'b1);
    set_lane(1, 0, 0, 0, 1, 0, 0, 0, 1, 1'b0, 1'b0);
    run_frame(DIGITS, 1'b1);
    check("frame_gap_cycles", acc_cyc[0] - t3, 3);
    drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
